alu_acc_seq: RTL and testbench
==============================

Name: alu_acc_seq

Overview:
- Parameterised accumulator ALU that succeeds the 8-bit single-cycle ALU.
- Keeps that ALU's opcode map and on/off power control, and adds:
  - a valid/ready operation handshake;
  - a multi-cycle shift-add multiplier;
  - shift ops;
  - status flags (Z/N/C) and illegal-opcode reporting.
- Sits between the operand/opcode sequencer and the result consumer, with the accumulator as the sole architectural state.

Parameters:
- N, 8, datapath and accumulator width in bits (N >= 2).
- OPW, 4, opcode width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- op_valid  in  1  operation request.
- op_ready  out  1  block can accept an op this cycle.
- op  in  OPW  opcode: 0 NOP, 1 LOAD, 2 NOT, 3 XOR, 4 OR, 5 AND, 6 SUB, 7 ADD, 8 MULT, 9 SHL, 10 SHR; 11..15 illegal.
- in  in  N  operand B (operand A is the accumulator).
- on  in  1  power-on request.
- off  in  1  power-off request.
- out  out  N  accumulator value.
- done  out  1  one-cycle pulse when an accepted op completes.
- flag_z, flag_n, flag_c  out  1 each  zero, MSB, carry/borrow/overflow.
- op_err  out  1  one-cycle pulse when an illegal opcode is accepted.
- pwr  out  1  1 when the block is ON.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE (ON);
  - out=0, all flags=0, done=0, op_err=0, pwr=1;
  - multiplier counter cleared.
  - Reset taken mid-MULT aborts the multiply with no residue.
- States:
  - OFF: pwr=0, op_ready=0; op_valid is ignored; out and flags hold.
  - IDLE: pwr=1, op_ready=1.
  - MUL: pwr=1, op_ready=0.
- Transfers: an op is accepted on a rising edge when op_valid && op_ready; op and in are sampled at acceptance only.
- Power control:
  - on=1 in any state: go to IDLE, or stay there.
  - off=1 (with on=0) in IDLE or MUL: go to OFF. In MUL this aborts the multiply; out and flags keep their pre-MULT values; no done.
  - on and off both high: on wins.
  - Power requests take priority over an op offered in the same cycle. off=1 in IDLE blocks acceptance; op_ready is combinationally low that cycle.
- Single-cycle ops (NOP, LOAD, NOT, XOR, OR, AND, SUB, ADD, SHL, SHR):
  - out updates on the accept edge; done=1 in the following cycle.
- Per-op results:
  - ADD: out = (out+in) mod 2^N; C = carry out.
  - SUB: out = (out-in) mod 2^N; C = borrow (out < in unsigned).
  - SHL: out = out << in[$clog2(N)-1:0]; C = last bit shifted out (0 if shift is 0).
  - SHR: logical shift, with C defined the same way.
  - LOAD/NOT/XOR/OR/AND: C=0.
  - NOP: out and all flags unchanged; done still pulses.
- Flags: Z = (new out == 0) and N = new out[N-1], updated by every op except NOP.
- Illegal opcode: treated as NOP for out and flags; op_err and done pulse together.
- MULT:
  - On accept: latch multiplicand = out and multiplier = in, clear the 2N-bit product, go to MUL.
  - One shift-add step per cycle for N cycles.
  - On the final step: out = product[N-1:0]; C = |product[2N-1:N]; Z and N updated; return to IDLE; done pulses the next cycle.
  - Latency is exactly N+1 cycles from accept edge to done.
  - op_ready is low for N cycles; the next op can be accepted on the cycle done is high.
- out changes only on accept edges of single-cycle ops or on the final MULT step, never during MUL.

Optional Feature:
- ALU_SAT_EN defined:
  - ADD clamps to 2^N-1 on carry; SUB clamps to 0 on borrow.
  - MULT clamps to 2^N-1 when the upper half is nonzero.
  - C still reports that saturation occurred.
- ALU_SAT_EN undefined: wrap-around arithmetic exactly as above.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_NOP..OP_SHR);
  - a power/state enum (ST_OFF, ST_IDLE, ST_MUL);
  - a flag-index constant.
- One sub-module, alu_shift_mult: sequential N-step shift-add multiplier.
  - Ports: clk, rst, start, abort, a, b → busy, last, product[2N-1:0].
  - Instantiated once.

Test Plan:
- Reset then ADD in=16, then ADD in=2 → out 16 then 18; done pulses each; Z=0, C=0.
- out=250, ADD in=10 → out=4, C=1. With ALU_SAT_EN → out=255, C=1.
- out=6, SUB in=7 → out=255, C=1, N=1. Then MULT in=4 → op_ready low for 8 cycles, done on cycle 9, out=252, C=1.
- MULT accepted, off=1 on the 3rd busy cycle → pwr=0, no done, out holds the pre-MULT value. Ops offered while OFF are ignored. on=1 → pwr=1, op_ready=1 next cycle.
- on=1 and off=1 together while OFF → ends ON. rst asserted mid-MULT → out=0, flags=0 immediately (async).
- op=12 → op_err and done pulse, out unchanged. out=0x81, SHL in=1 → out=0x02, C=1. Then SHR in=1 → out=0x01, C=0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcodes, power/state encoding and flag indices for alu_acc_seq
// Revision : 1.0
// ============================================================================
package alu_pkg;

  localparam int unsigned OP_NOP  = 0;
  localparam int unsigned OP_LOAD = 1;
  localparam int unsigned OP_NOT  = 2;
  localparam int unsigned OP_XOR  = 3;
  localparam int unsigned OP_OR   = 4;
  localparam int unsigned OP_AND  = 5;
  localparam int unsigned OP_SUB  = 6;
  localparam int unsigned OP_ADD  = 7;
  localparam int unsigned OP_MULT = 8;
  localparam int unsigned OP_SHL  = 9;
  localparam int unsigned OP_SHR  = 10;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_IDLE = 2'd1,
    ST_MUL  = 2'd2
  } pwr_state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int NFLAGS = 3;

endpackage
`default_nettype wire

// File: rtl/alu_shift_mult.sv
`default_nettype none
// ============================================================================
// Module   : alu_shift_mult
// Brief    : N-step sequential shift-add multiplier, one step per cycle
// Revision : 1.0
// ============================================================================
module alu_shift_mult #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           last,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N);

  logic [2*N-1:0] r_mcand;
  logic [2*N-1:0] r_prod;
  logic [N-1:0]   r_mplier;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic [2*N-1:0] w_prod_next;

  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign busy        = r_busy;
  assign last        = r_busy && (r_cnt == CW'(N-1));
  // Includes the step taken on the coming edge, so it is final while last=1
  assign product     = w_prod_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (abort) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (start) begin
      r_mcand  <= {{N{1'b0}}, a};
      r_mplier <= b;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_prod   <= w_prod_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (last) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_acc_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_acc_seq
// Brief    : Accumulator ALU with handshake, power control, shift-add MULT.
//            Define ALU_SAT_EN for saturating ADD/SUB/MULT.
// Revision : 1.0
// ============================================================================
module alu_acc_seq
  import alu_pkg::*;
#(
  parameter int N   = 8,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [OPW-1:0] op,
  input  logic [N-1:0]   in,
  input  logic           on,
  input  logic           off,
  output logic [N-1:0]   out,
  output logic           done,
  output logic           flag_z,
  output logic           flag_n,
  output logic           flag_c,
  output logic           op_err,
  output logic           pwr
);

  localparam int SW = $clog2(N);

  pwr_state_e        r_state, w_state_next;
  logic [N-1:0]      r_acc;
  logic [NFLAGS-1:0] r_flags;
  logic              r_done, r_err;

  logic              w_accept, w_start, w_abort, w_mul_fin;
  logic              w_mbusy, w_mlast;
  logic [2*N-1:0]    w_prod;
  logic [N:0]        w_sum, w_diff, w_shl, w_shr;
  logic [SW-1:0]     w_sh;
  logic [N-1:0]      w_res, w_mres;
  logic              w_c, w_mc, w_upd, w_illegal;

  assign w_accept  = op_valid && op_ready;
  assign w_start   = w_accept && (op == OPW'(OP_MULT));
  assign w_abort   = (r_state == ST_MUL) && (on || off);
  assign w_mul_fin = w_mlast && !w_abort;

  alu_shift_mult #(.N(N)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (w_start),
    .abort   (w_abort),
    .a       (r_acc),
    .b       (in),
    .busy    (w_mbusy),
    .last    (w_mlast),
    .product (w_prod)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // Power requests outrank everything; on outranks off
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_OFF:  if (on) w_state_next = ST_IDLE;
      ST_IDLE: begin
        if (on)           w_state_next = ST_IDLE;
        else if (off)     w_state_next = ST_OFF;
        else if (w_start) w_state_next = ST_MUL;
      end
      ST_MUL: begin
        if (on)             w_state_next = ST_IDLE;
        else if (off)       w_state_next = ST_OFF;
        else if (w_mul_fin) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    pwr      = (r_state != ST_OFF);
    op_ready = (r_state == ST_IDLE) && !on && !off;
  end

  assign w_sum  = {1'b0, r_acc} + {1'b0, in};
  assign w_diff = {1'b0, r_acc} - {1'b0, in};
  assign w_sh   = in[SW-1:0];
  // The extra bit catches the last bit shifted out (zero for a shift of 0)
  assign w_shl  = {1'b0, r_acc} << w_sh;
  assign w_shr  = {r_acc, 1'b0} >> w_sh;

  always_comb begin
    w_res     = r_acc;
    w_c       = 1'b0;
    w_upd     = 1'b1;
    w_illegal = 1'b0;
    case (op)
      OPW'(OP_NOP):  w_upd = 1'b0;
      OPW'(OP_LOAD): w_res = in;
      OPW'(OP_NOT):  w_res = ~r_acc;
      OPW'(OP_XOR):  w_res = r_acc ^ in;
      OPW'(OP_OR):   w_res = r_acc | in;
      OPW'(OP_AND):  w_res = r_acc & in;
      OPW'(OP_SUB): begin
        w_c = w_diff[N];
`ifdef ALU_SAT_EN
        w_res = w_diff[N] ? '0 : w_diff[N-1:0];
`else
        w_res = w_diff[N-1:0];
`endif
      end
      OPW'(OP_ADD): begin
        w_c = w_sum[N];
`ifdef ALU_SAT_EN
        w_res = w_sum[N] ? '1 : w_sum[N-1:0];
`else
        w_res = w_sum[N-1:0];
`endif
      end
      OPW'(OP_MULT): w_upd = 1'b0;
      OPW'(OP_SHL): begin
        w_res = w_shl[N-1:0];
        w_c   = w_shl[N];
      end
      OPW'(OP_SHR): begin
        w_res = w_shr[N:1];
        w_c   = w_shr[0];
      end
      default: begin
        w_upd     = 1'b0;
        w_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_mc = |w_prod[2*N-1:N];
`ifdef ALU_SAT_EN
    w_mres = w_mc ? '1 : w_prod[N-1:0];
`else
    w_mres = w_prod[N-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc   <= '0;
      r_flags <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_accept && !w_start) begin
        r_done <= 1'b1;
        r_err  <= w_illegal;
        if (w_upd) begin
          r_acc           <= w_res;
          r_flags[FLAG_Z] <= (w_res == '0);
          r_flags[FLAG_N] <= w_res[N-1];
          r_flags[FLAG_C] <= w_c;
        end
      end else if (w_mul_fin && w_mbusy) begin
        r_done          <= 1'b1;
        r_acc           <= w_mres;
        r_flags[FLAG_Z] <= (w_mres == '0);
        r_flags[FLAG_N] <= w_mres[N-1];
        r_flags[FLAG_C] <= w_mc;
      end
    end
  end

  assign out    = r_acc;
  assign done   = r_done;
  assign op_err = r_err;
  assign flag_z = r_flags[FLAG_Z];
  assign flag_n = r_flags[FLAG_N];
  assign flag_c = r_flags[FLAG_C];

endmodule
`default_nettype wire

// File: tb/tb_alu_acc_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_acc_seq
// Brief    : Directed self-checking bench for alu_acc_seq (N=8)
// Revision : 1.0
// ============================================================================
module tb_alu_acc_seq;

  localparam int N   = 8;
  localparam int OPW = 4;

  localparam logic [3:0] C_NOP = 4'd0, C_LOAD = 4'd1, C_NOT = 4'd2, C_XOR = 4'd3,
                         C_OR = 4'd4, C_AND = 4'd5, C_SUB = 4'd6, C_ADD = 4'd7,
                         C_MULT = 4'd8, C_SHL = 4'd9, C_SHR = 4'd10;

`ifdef ALU_SAT_EN
  localparam logic [7:0] E_ADD = 8'hFF, E_SUB = 8'h00, E_MUL = 8'hFF;
  localparam logic       E_ADD_N = 1'b1, E_SUB_N = 1'b0, E_SUB_Z = 1'b1;
`else
  localparam logic [7:0] E_ADD = 8'h04, E_SUB = 8'hFF, E_MUL = 8'hFC;
  localparam logic       E_ADD_N = 1'b0, E_SUB_N = 1'b1, E_SUB_Z = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, op_valid, on, off;
  logic [3:0] op;
  logic [7:0] in;
  logic       op_ready, done, flag_z, flag_n, flag_c, op_err, pwr;
  logic [7:0] out;

  int errors = 0;
  int checks = 0;
  int busy_cnt;
  logic held, saw_done;

  always #5 clk = ~clk;

  alu_acc_seq #(.N(N), .OPW(OPW)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .in(in), .on(on), .off(off), .out(out), .done(done), .flag_z(flag_z),
    .flag_n(flag_n), .flag_c(flag_c), .op_err(op_err), .pwr(pwr)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [3:0] o, input logic [7:0] v);
    op_valid = 1'b1;
    op       = o;
    in       = v;
    tick();
    op_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; op_valid = 1'b0; on = 1'b0; off = 1'b0; op = '0; in = '0;
    tick(); tick();
    chk8("rst_out", out, 8'h00);
    chk8("rst_flags", {5'b0, flag_z, flag_n, flag_c}, 8'h00);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", op_err, 1'b0);
    chk1("rst_pwr", pwr, 1'b1);
    rst = 1'b1;
    tick();
    chk1("idle_ready", op_ready, 1'b1);

    do_op(C_ADD, 8'd16);
    chk8("add16_out", out, 8'd16);
    chk1("add16_done", done, 1'b1);
    do_op(C_ADD, 8'd2);
    chk8("add2_out", out, 8'd18);
    chk1("add2_done", done, 1'b1);
    chk1("add2_z", flag_z, 1'b0);
    chk1("add2_c", flag_c, 1'b0);
    tick();
    chk1("done_clear", done, 1'b0);

    do_op(C_LOAD, 8'd250);
    do_op(C_ADD, 8'd10);
    chk8("addc_out", out, E_ADD);
    chk1("addc_c", flag_c, 1'b1);
    chk1("addc_n", flag_n, E_ADD_N);

    do_op(C_LOAD, 8'd6);
    do_op(C_SUB, 8'd7);
    chk8("sub_out", out, E_SUB);
    chk1("sub_c", flag_c, 1'b1);
    chk1("sub_n", flag_n, E_SUB_N);
    chk1("sub_z", flag_z, E_SUB_Z);

    // MULT 255*4: ready low for N cycles, done in cycle N+1
    do_op(C_LOAD, 8'hFF);
    do_op(C_MULT, 8'd4);
    busy_cnt = 0;
    held = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (!op_ready && !done) busy_cnt++;
      if (out !== 8'hFF) held = 1'b0;
      tick();
    end
    chki("mul_busy_cycles", busy_cnt, N);
    chk1("mul_out_held", held, 1'b1);
    chk1("mul_done", done, 1'b1);
    chk1("mul_ready_on_done", op_ready, 1'b1);
    chk8("mul_out", out, E_MUL);
    chk1("mul_c", flag_c, 1'b1);
    do_op(C_NOP, 8'h00);
    chk1("nop_done", done, 1'b1);
    chk8("nop_out", out, E_MUL);
    chk8("nop_flags", {5'b0, flag_z, flag_n, flag_c}, 8'b011);
    tick();
    chk1("nop_done_clear", done, 1'b0);

    // off on the 3rd busy cycle aborts the multiply
    do_op(C_LOAD, 8'h33);
    do_op(C_MULT, 8'd3);
    tick(); tick();
    off = 1'b1;
    tick();
    off = 1'b0;
    chk1("abort_pwr", pwr, 1'b0);
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) saw_done = 1'b1;
      op_valid = 1'b1; op = C_LOAD; in = 8'hAA;
      tick();
    end
    op_valid = 1'b0;
    chk1("abort_no_done", saw_done, 1'b0);
    chk8("abort_out_held", out, 8'h33);
    chk1("abort_c_held", flag_c, 1'b0);
    chk1("off_ready", op_ready, 1'b0);
    on = 1'b1;
    #1;
    chk1("on_ready_same_cycle", op_ready, 1'b0);
    tick();
    on = 1'b0;
    #1;
    chk1("on_pwr", pwr, 1'b1);
    chk1("on_ready", op_ready, 1'b1);

    off = 1'b1;
    #1;
    chk1("off_blocks_ready", op_ready, 1'b0);
    tick();
    off = 1'b0;
    chk1("off_pwr", pwr, 1'b0);
    on = 1'b1; off = 1'b1;
    tick();
    on = 1'b0; off = 1'b0;
    chk1("on_wins_pwr", pwr, 1'b1);

    // async reset in the middle of a multiply
    do_op(C_LOAD, 8'h80);
    chk1("load80_n", flag_n, 1'b1);
    do_op(C_MULT, 8'd5);
    tick(); tick();
    #3 rst = 1'b0;
    #1;
    chk8("arst_out", out, 8'h00);
    chk8("arst_flags", {5'b0, flag_z, flag_n, flag_c}, 8'h00);
    chk1("arst_pwr", pwr, 1'b1);
    #2 rst = 1'b1;
    tick();
    chk1("arst_ready", op_ready, 1'b1);
    do_op(C_LOAD, 8'd7);
    do_op(C_MULT, 8'd3);
    repeat (N) tick();
    chk1("mul2_done", done, 1'b1);
    chk8("mul2_out", out, 8'd21);
    chk1("mul2_c", flag_c, 1'b0);

    do_op(4'd12, 8'h55);
    chk1("illegal_err", op_err, 1'b1);
    chk1("illegal_done", done, 1'b1);
    chk8("illegal_out", out, 8'd21);
    tick();
    chk1("illegal_err_clear", op_err, 1'b0);

    do_op(C_LOAD, 8'h0F);
    do_op(C_XOR, 8'hFF);
    chk8("xor_out", out, 8'hF0);
    chk1("xor_n", flag_n, 1'b1);
    do_op(C_NOT, 8'h00);
    chk8("not_out", out, 8'h0F);
    do_op(C_AND, 8'hF0);
    chk8("and_out", out, 8'h00);
    chk1("and_z", flag_z, 1'b1);
    do_op(C_OR, 8'h3C);
    chk8("or_out", out, 8'h3C);

    do_op(C_LOAD, 8'h81);
    do_op(C_SHL, 8'd1);
    chk8("shl_out", out, 8'h02);
    chk1("shl_c", flag_c, 1'b1);
    do_op(C_SHR, 8'd1);
    chk8("shr_out", out, 8'h01);
    chk1("shr_c", flag_c, 1'b0);
    do_op(C_SHR, 8'd1);
    chk8("shr2_out", out, 8'h00);
    chk1("shr2_c", flag_c, 1'b1);
    chk1("shr2_z", flag_z, 1'b1);
    do_op(C_SHL, 8'd0);
    chk1("shl0_c", flag_c, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
